// File: rtl/gate_checker.sv
// Scoreboard for a single 1-bit logic gate: predicts the gate output for each accepted
// stimulus, compares it with dut_y after LATENCY cycles and reports a PASS/FAIL verdict.
// Optional first-error capture ports are compiled in with GATE_CHECKER_ERR_LOG_EN.
module gate_checker #(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic [2:0]       gate_sel,
    input  logic             stim_valid,
    input  logic             stim_a,
    input  logic             stim_b,
    input  logic             dut_y,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic             mismatch,
    output logic [CNT_W-1:0] checks,
    output logic [CNT_W-1:0] errors,
`ifdef GATE_CHECKER_ERR_LOG_EN
    output logic [CNT_W-1:0] err_idx,
    output logic             err_exp,
    output logic             err_act,
    output logic [2:0]       err_gate,
`endif
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PASS = 2'd2;
    localparam logic [1:0] S_FAIL = 2'd3;

    // A zero-latency build still keeps a one-entry pipeline so the shift logic is uniform;
    // its contents are simply never selected for compare.
    localparam int PD = (LATENCY > 0) ? LATENCY : 1;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic ref_gate(input logic [2:0] sel, input logic a, input logic b);
        case (sel)
            3'd0:    ref_gate = ~a;
            3'd1:    ref_gate = a & b;
            3'd2:    ref_gate = a | b;
            3'd3:    ref_gate = a ^ b;
            3'd4:    ref_gate = ~(a & b);
            3'd5:    ref_gate = ~(a | b);
            3'd6:    ref_gate = ~(a ^ b);
            default: ref_gate = a;
        endcase
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] nv_q, nv_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] checks_q, checks_d;
    logic [CNT_W-1:0] errors_q, errors_d;
    logic [PD-1:0]    pv_q, pv_d;
    logic [PD-1:0]    pe_q, pe_d;
    logic             mismatch_q, mismatch_d;
    logic             busy_q, pass_q, fail_q;

    logic run, start_acc, accept, exp_now, cmp_valid, cmp_exp, cmp_bad;

`ifdef GATE_CHECKER_ERR_LOG_EN
    logic [2:0]       pg_q [PD];
    logic [2:0]       pg_d [PD];
    logic [2:0]       cmp_gate;
    logic [CNT_W-1:0] err_idx_q, err_idx_d;
    logic             err_exp_q, err_exp_d;
    logic             err_act_q, err_act_d;
    logic [2:0]       err_gate_q, err_gate_d;
`endif

    always_comb begin
        run       = (state_q == S_RUN);
        start_acc = start && !run;
        exp_now   = ref_gate(gate_sel, stim_a, stim_b);
        accept    = run && stim_valid && (issued_q < nv_q);
        cmp_valid = run && ((LATENCY == 0) ? accept : pv_q[PD-1]);
        cmp_exp   = (LATENCY == 0) ? exp_now : pe_q[PD-1];
        cmp_bad   = cmp_valid && (dut_y != cmp_exp);

        pv_d[0] = accept;
        pe_d[0] = exp_now;
        for (int i = 1; i < PD; i++) begin
            pv_d[i] = pv_q[i-1];
            pe_d[i] = pe_q[i-1];
        end

        state_d    = state_q;
        nv_d       = nv_q;
        issued_d   = issued_q;
        checks_d   = checks_q;
        errors_d   = errors_q;
        mismatch_d = cmp_bad;

        if (start_acc) begin
            state_d    = S_RUN;
            nv_d       = num_vectors;
            issued_d   = '0;
            checks_d   = '0;
            errors_d   = '0;
            pv_d       = '0;
            mismatch_d = 1'b0;
        end else if (run) begin
            if (accept) begin
                issued_d = issued_q + CNT_ONE;
            end
            if (cmp_valid && (checks_q != CNT_MAX)) begin
                checks_d = checks_q + CNT_ONE;
            end
            if (cmp_bad && (errors_q != CNT_MAX)) begin
                errors_d = errors_q + CNT_ONE;
            end
            // The verdict sees this cycle's compare, so a failing last vector still fails.
            if (checks_d == nv_q) begin
                state_d = (errors_d == '0) ? S_PASS : S_FAIL;
            end
        end
    end

`ifdef GATE_CHECKER_ERR_LOG_EN
    always_comb begin
        pg_d[0] = gate_sel;
        for (int i = 1; i < PD; i++) begin
            pg_d[i] = pg_q[i-1];
        end
        cmp_gate   = (LATENCY == 0) ? gate_sel : pg_q[PD-1];
        err_idx_d  = err_idx_q;
        err_exp_d  = err_exp_q;
        err_act_d  = err_act_q;
        err_gate_d = err_gate_q;
        if (start_acc) begin
            err_idx_d  = '0;
            err_exp_d  = 1'b0;
            err_act_d  = 1'b0;
            err_gate_d = '0;
        end else if (cmp_bad && (errors_q == '0)) begin
            // checks_q is the zero-based index of the vector being compared.
            err_idx_d  = checks_q;
            err_exp_d  = cmp_exp;
            err_act_d  = dut_y;
            err_gate_d = cmp_gate;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PD; i++) begin
                pg_q[i] <= '0;
            end
            err_idx_q  <= '0;
            err_exp_q  <= 1'b0;
            err_act_q  <= 1'b0;
            err_gate_q <= '0;
        end else begin
            for (int i = 0; i < PD; i++) begin
                pg_q[i] <= pg_d[i];
            end
            err_idx_q  <= err_idx_d;
            err_exp_q  <= err_exp_d;
            err_act_q  <= err_act_d;
            err_gate_q <= err_gate_d;
        end
    end

    assign err_idx  = err_idx_q;
    assign err_exp  = err_exp_q;
    assign err_act  = err_act_q;
    assign err_gate = err_gate_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            nv_q       <= '0;
            issued_q   <= '0;
            checks_q   <= '0;
            errors_q   <= '0;
            pv_q       <= '0;
            pe_q       <= '0;
            mismatch_q <= 1'b0;
            busy_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            nv_q       <= nv_d;
            issued_q   <= issued_d;
            checks_q   <= checks_d;
            errors_q   <= errors_d;
            pv_q       <= pv_d;
            pe_q       <= pe_d;
            mismatch_q <= mismatch_d;
            busy_q     <= (state_d == S_RUN);
            pass_q     <= (state_d == S_PASS);
            fail_q     <= (state_d == S_FAIL);
        end
    end

    assign busy      = busy_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign mismatch  = mismatch_q;
    assign checks    = checks_q;
    assign errors    = errors_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_gate_checker.sv
// Bench for gate_checker: three instances (LATENCY 1, 0, 7) share stimulus, each fed by its
// own delayed ideal-gate model; verdicts are queued as expectations and popped at run end.
module tb_gate_checker;

    localparam int CNT_W = 16;
    localparam int W     = 2 + 2 * CNT_W;
    localparam int HN    = 4096;
    // Truth tables indexed by {sel, a, b}: BUF XNOR NOR NAND XOR OR AND NOT (sel 7..0).
    localparam logic [31:0] TT_TABLE = {4'b1100, 4'b1001, 4'b0001, 4'b0111,
                                        4'b0110, 4'b1110, 4'b1000, 4'b0011};

    logic             clk = 1'b0;
    logic             rst, start, stim_valid, stim_a, stim_b;
    logic [CNT_W-1:0] num_vectors;
    logic [2:0]       gate_sel;
    logic             y0, y1, y7;

    logic             busy0, pass0, fail0, mm0;
    logic             busy1, pass1, fail1, mm1;
    logic             busy7, pass7, fail7, mm7;
    logic [CNT_W-1:0] checks0, errors0, checks1, errors1, checks7, errors7;
    logic [1:0]       st0, st1, st7;
`ifdef GATE_CHECKER_ERR_LOG_EN
    logic [CNT_W-1:0] eidx0, eidx1, eidx7;
    logic             eexp0, eexp1, eexp7, eact0, eact1, eact7;
    logic [2:0]       egate0, egate1, egate7;
`endif

    logic [W-1:0] exp_q[$];
    logic         ideal [HN];
    int           cyc, skew;
    bit           stuck;
    int           n_checks, n_pass;
    int           mm0_tot, mm1_tot, mm7_tot;

    always #5 clk = ~clk;

    gate_checker #(.LATENCY(1), .CNT_W(CNT_W)) u_l1 (
        .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors), .gate_sel(gate_sel),
        .stim_valid(stim_valid), .stim_a(stim_a), .stim_b(stim_b), .dut_y(y1),
        .busy(busy1), .pass(pass1), .fail(fail1), .mismatch(mm1),
        .checks(checks1), .errors(errors1),
`ifdef GATE_CHECKER_ERR_LOG_EN
        .err_idx(eidx1), .err_exp(eexp1), .err_act(eact1), .err_gate(egate1),
`endif
        .state_dbg(st1)
    );

    gate_checker #(.LATENCY(0), .CNT_W(CNT_W)) u_l0 (
        .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors), .gate_sel(gate_sel),
        .stim_valid(stim_valid), .stim_a(stim_a), .stim_b(stim_b), .dut_y(y0),
        .busy(busy0), .pass(pass0), .fail(fail0), .mismatch(mm0),
        .checks(checks0), .errors(errors0),
`ifdef GATE_CHECKER_ERR_LOG_EN
        .err_idx(eidx0), .err_exp(eexp0), .err_act(eact0), .err_gate(egate0),
`endif
        .state_dbg(st0)
    );

    gate_checker #(.LATENCY(7), .CNT_W(CNT_W)) u_l7 (
        .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors), .gate_sel(gate_sel),
        .stim_valid(stim_valid), .stim_a(stim_a), .stim_b(stim_b), .dut_y(y7),
        .busy(busy7), .pass(pass7), .fail(fail7), .mismatch(mm7),
        .checks(checks7), .errors(errors7),
`ifdef GATE_CHECKER_ERR_LOG_EN
        .err_idx(eidx7), .err_exp(eexp7), .err_act(eact7), .err_gate(egate7),
`endif
        .state_dbg(st7)
    );

    always @(negedge clk) begin
        if (mm0 === 1'b1) mm0_tot++;
        if (mm1 === 1'b1) mm1_tot++;
        if (mm7 === 1'b1) mm7_tot++;
    end

    function automatic logic ref_f(input logic [2:0] sel, input logic a, input logic b);
        logic [31:0] tt;
        tt = TT_TABLE;
        return tt[{sel, a, b}];
    endfunction

    // Output of the modelled gate under test, d cycles after its stimulus cycle.
    function automatic logic pick(input int d);
        int idx;
        idx = cyc - d - skew;
        if (stuck || idx < 0) return 1'b0;
        return ideal[idx % HN];
    endfunction

    task automatic step(input bit st, input bit v, input bit a, input bit b);
        start      = st;
        stim_valid = v;
        stim_a     = a;
        stim_b     = b;
        cyc++;
        ideal[cyc % HN] = v ? ref_f(gate_sel, a, b) : 1'b0;
        y0 = pick(0);
        y1 = pick(1);
        y7 = pick(7);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_all_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!busy0 && !busy1 && !busy7) begin
                ok = 1'b1;
                return;
            end
            step(0, 0, 0, 0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst = 1'b0;
        n_checks++;
        if ({busy1, pass1, fail1, mm1, checks1, errors1} !== '0)
            $display("FAIL reset_l1: got %b %b %b %b %0d %0d want all 0",
                     busy1, pass1, fail1, mm1, checks1, errors1);
        else n_pass++;
        n_checks++;
        if ({busy0, pass0, fail0, mm0, checks0, errors0} !== '0)
            $display("FAIL reset_l0: got %b %b %b %b %0d %0d want all 0",
                     busy0, pass0, fail0, mm0, checks0, errors0);
        else n_pass++;
        n_checks++;
        if ({busy7, pass7, fail7, mm7, checks7, errors7} !== '0)
            $display("FAIL reset_l7: got %b %b %b %b %0d %0d want all 0",
                     busy7, pass7, fail7, mm7, checks7, errors7);
        else n_pass++;
`ifdef GATE_CHECKER_ERR_LOG_EN
        n_checks++;
        if ({eidx1, eexp1, eact1, egate1} !== '0)
            $display("FAIL reset_errlog: got idx=%0d exp=%b act=%b gate=%0d want 0",
                     eidx1, eexp1, eact1, egate1);
        else n_pass++;
`endif
    endtask

    task automatic test_not_pass();
        bit ok;
        int mm_start;
        logic [W-1:0] e;
        wait_all_idle(ok);
        gate_sel    = 3'd0;
        num_vectors = 16'd2;
        mm_start    = mm1_tot;
        exp_q.push_back({1'b1, 1'b0, 16'd2, 16'd0});
        step(1, 0, 0, 0);
        n_checks++;
        if (busy1 !== 1'b1) $display("FAIL not_busy: got %b want 1", busy1);
        else n_pass++;
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        wait_all_idle(ok);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || {pass1, fail1, checks1, errors1} !== e)
            $display("FAIL not_verdict: got p=%b f=%b c=%0d e=%0d idle=%0d want %h",
                     pass1, fail1, checks1, errors1, ok, e);
        else n_pass++;
        n_checks++;
        if (mm1_tot - mm_start != 0)
            $display("FAIL not_mismatch: got %0d pulses want 0", mm1_tot - mm_start);
        else n_pass++;
    endtask

    task automatic test_and_stuck();
        bit ok;
        int mm_start;
        logic [W-1:0] e;
        wait_all_idle(ok);
        gate_sel    = 3'd1;
        num_vectors = 16'd4;
        stuck       = 1'b1;
        mm_start    = mm1_tot;
        exp_q.push_back({1'b0, 1'b1, 16'd4, 16'd1});
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, i[1], i[0]);
        wait_all_idle(ok);
        step(0, 0, 0, 0);
        stuck = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || {pass1, fail1, checks1, errors1} !== e)
            $display("FAIL and_verdict: got p=%b f=%b c=%0d e=%0d idle=%0d want %h",
                     pass1, fail1, checks1, errors1, ok, e);
        else n_pass++;
        n_checks++;
        if (mm1_tot - mm_start != 1)
            $display("FAIL and_mismatch: got %0d pulses want 1", mm1_tot - mm_start);
        else n_pass++;
`ifdef GATE_CHECKER_ERR_LOG_EN
        n_checks++;
        if ({eidx1, eexp1, eact1, egate1} !== {16'd3, 1'b1, 1'b0, 3'd1})
            $display("FAIL and_errlog: got idx=%0d exp=%b act=%b gate=%0d want 3 1 0 1",
                     eidx1, eexp1, eact1, egate1);
        else n_pass++;
`endif
    endtask

    task automatic test_zero_vectors();
        bit ok;
        wait_all_idle(ok);
        num_vectors = 16'd0;
        step(1, 0, 0, 0);
        n_checks++;
        if (pass1 !== 1'b0 || busy1 !== 1'b1)
            $display("FAIL zero_early: got pass=%b busy=%b want 0 1", pass1, busy1);
        else n_pass++;
        step(0, 0, 0, 0);
        n_checks++;
        if (pass1 !== 1'b1 || fail1 !== 1'b0 || checks1 !== 16'd0)
            $display("FAIL zero_pass: got pass=%b fail=%b checks=%0d want 1 0 0",
                     pass1, fail1, checks1);
        else n_pass++;
    endtask

    task automatic test_extra_stimuli();
        bit ok;
        logic [W-1:0] e;
        wait_all_idle(ok);
        gate_sel    = 3'($urandom_range(0, 7));
        num_vectors = 16'd3;
        for (int k = 0; k < 3; k++) exp_q.push_back({1'b1, 1'b0, 16'd3, 16'd0});
        step(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        wait_all_idle(ok);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || {pass1, fail1, checks1, errors1} !== e)
            $display("FAIL extra_l1: got p=%b f=%b c=%0d e=%0d want %h", pass1, fail1, checks1, errors1, e);
        else n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || {pass0, fail0, checks0, errors0} !== e)
            $display("FAIL extra_l0: got p=%b f=%b c=%0d e=%0d want %h", pass0, fail0, checks0, errors0, e);
        else n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || {pass7, fail7, checks7, errors7} !== e)
            $display("FAIL extra_l7: got p=%b f=%b c=%0d e=%0d want %h", pass7, fail7, checks7, errors7, e);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        logic [W-1:0] e;
        wait_all_idle(ok);
        gate_sel    = 3'd3;
        num_vectors = 16'd4;
        step(1, 0, 0, 0);
        step(0, 1, 0, 1);
        step(0, 1, 1, 1);
        rst = 1'b1;
        step(0, 0, 0, 0);
        rst = 1'b0;
        n_checks++;
        if ({busy1, pass1, fail1, mm1, checks1, errors1} !== '0)
            $display("FAIL midrst_clear: got %b %b %b %b %0d %0d want all 0",
                     busy1, pass1, fail1, mm1, checks1, errors1);
        else n_pass++;
        num_vectors = 16'd2;
        exp_q.push_back({1'b1, 1'b0, 16'd2, 16'd0});
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        wait_all_idle(ok);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || {pass1, fail1, checks1, errors1} !== e)
            $display("FAIL midrst_rerun: got p=%b f=%b c=%0d e=%0d want %h", pass1, fail1, checks1, errors1, e);
        else n_pass++;
    endtask

    task automatic test_latency();
        bit ok;
        logic [W-1:0] e;
        for (int pass_no = 0; pass_no < 2; pass_no++) begin
            wait_all_idle(ok);
            gate_sel    = 3'd3;
            num_vectors = 16'd8;
            skew        = pass_no;
            // Correct timing passes; one-cycle-late output of an alternating 0,1,.. stream
            // misses every vector except the first.
            if (pass_no == 0) begin
                exp_q.push_back({1'b1, 1'b0, 16'd8, 16'd0});
                exp_q.push_back({1'b1, 1'b0, 16'd8, 16'd0});
            end else begin
                exp_q.push_back({1'b0, 1'b1, 16'd8, 16'd7});
                exp_q.push_back({1'b0, 1'b1, 16'd8, 16'd7});
            end
            step(1, 0, 0, 0);
            for (int i = 0; i < 8; i++) begin
                if (pass_no == 0) step(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                else              step(0, 1, 1'b0, i[0]);
            end
            wait_all_idle(ok);
            e = exp_q.pop_front();
            n_checks++;
            if (!ok || {pass0, fail0, checks0, errors0} !== e)
                $display("FAIL lat0_skew%0d: got p=%b f=%b c=%0d e=%0d want %h",
                         pass_no, pass0, fail0, checks0, errors0, e);
            else n_pass++;
            e = exp_q.pop_front();
            n_checks++;
            if (!ok || {pass7, fail7, checks7, errors7} !== e)
                $display("FAIL lat7_skew%0d: got p=%b f=%b c=%0d e=%0d want %h",
                         pass_no, pass7, fail7, checks7, errors7, e);
            else n_pass++;
        end
        skew = 0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stim_valid = 1'b0; stim_a = 1'b0; stim_b = 1'b0;
        num_vectors = '0; gate_sel = '0; y0 = 1'b0; y1 = 1'b0; y7 = 1'b0;
        cyc = 0; skew = 0; stuck = 1'b0; n_checks = 0; n_pass = 0;
        mm0_tot = 0; mm1_tot = 0; mm7_tot = 0;
        for (int i = 0; i < HN; i++) ideal[i] = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_not_pass();
        test_and_stuck();
        test_zero_vectors();
        test_extra_stimuli();
        test_reset_mid_run();
        test_latency();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
